// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a shared single-outstanding bus,
// with a four-region address decoder and a bus_ready timeout.
module bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic        m0_we,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic        m1_we,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,

   output logic        bus_valid,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_we,
   output logic [3:0]  bus_wstrb,
   output logic        sel_mem,
   output logic        sel_gpio,
   output logic        sel_uart,
   output logic        sel_i2c,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   // Value the wait counter holds during the last ACCESS cycle before timeout.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        last_grant;
   logic        gnt;
   logic [15:0] wait_cnt;
   logic [3:0]  sel_q;

   logic        pick_valid;
   logic        pick;
   logic [31:0] pick_addr;
   logic [31:0] pick_wdata;
   logic        pick_we;
   logic [3:0]  pick_wstrb;
   logic [3:0]  pick_sel;

   logic        resp_fire;
   logic        resp_master;
   logic        resp_err;
   logic [31:0] resp_data;

   // One-hot select, bit order {i2c, uart, gpio, mem}; zero means unmapped.
   function automatic logic [3:0] decode(input logic [3:0] region);
      case (region)
         4'h0:    decode = 4'b0001;
         4'h4:    decode = 4'b0010;
         4'h5:    decode = 4'b0100;
         4'h6:    decode = 4'b1000;
         default: decode = 4'b0000;
      endcase
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first, so no path infers a latch.
      pick_valid = 1'b0;
      pick       = 1'b0;
      if (m0_req && m1_req) begin
         pick_valid = 1'b1;
         pick       = ~last_grant;
      end else if (m0_req) begin
         pick_valid = 1'b1;
         pick       = 1'b0;
      end else if (m1_req) begin
         pick_valid = 1'b1;
         pick       = 1'b1;
      end
      pick_addr  = pick ? m1_addr  : m0_addr;
      pick_wdata = pick ? m1_wdata : m0_wdata;
      pick_we    = pick ? m1_we    : m0_we;
      pick_wstrb = pick ? m1_wstrb : m0_wstrb;
      pick_sel   = decode(pick_addr[31:28]);
   end

   // Completion of the current transfer on this edge, and what it reports.
   always_comb begin
      resp_fire   = 1'b0;
      resp_master = gnt;
      resp_err    = 1'b0;
      resp_data   = 32'h0;
      case (state)
         IDLE: begin
            if (pick_valid && (pick_sel == 4'b0000)) begin
               resp_fire   = 1'b1;
               resp_master = pick;
               resp_err    = 1'b1;
            end
         end
         ACCESS: begin
            if (bus_ready) begin
               resp_fire = 1'b1;
               resp_data = bus_we ? 32'h0 : bus_rdata;
            end else if (wait_cnt == TIMEOUT_LAST) begin
               resp_fire = 1'b1;
               resp_err  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         wait_cnt   <= 16'h0;
         sel_q      <= 4'b0000;
         bus_valid  <= 1'b0;
         bus_addr   <= 32'h0;
         bus_wdata  <= 32'h0;
         bus_we     <= 1'b0;
         bus_wstrb  <= 4'h0;
         m0_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m0_rdata   <= 32'h0;
         m1_ack     <= 1'b0;
         m1_err     <= 1'b0;
         m1_rdata   <= 32'h0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;

         if (resp_fire) begin
            if (resp_master) begin
               m1_ack   <= 1'b1;
               m1_err   <= resp_err;
               m1_rdata <= resp_data;
            end else begin
               m0_ack   <= 1'b1;
               m0_err   <= resp_err;
               m0_rdata <= resp_data;
            end
         end

         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt        <= pick;
                  last_grant <= pick;
                  bus_addr   <= pick_addr;
                  bus_wdata  <= pick_wdata;
                  bus_we     <= pick_we;
                  bus_wstrb  <= pick_we ? pick_wstrb : 4'h0;
                  wait_cnt   <= 16'h0;
                  if (pick_sel != 4'b0000) begin
                     state     <= ACCESS;
                     bus_valid <= 1'b1;
                     sel_q     <= pick_sel;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (resp_fire) begin
                  state     <= RESP;
                  bus_valid <= 1'b0;
                  sel_q     <= 4'b0000;
                  wait_cnt  <= 16'h0;
               end else begin
                  wait_cnt <= wait_cnt + 16'h1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sel_mem  = sel_q[0];
   assign sel_gpio = sel_q[1];
   assign sel_uart = sel_q[2];
   assign sel_i2c  = sel_q[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT_CYCLES = 4); inputs are
// driven and outputs sampled on the falling clock edge.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        bus_valid, bus_we, bus_ready;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;
   logic        sel_mem, sel_gpio, sel_uart, sel_i2c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_we(bus_we), .bus_wstrb(bus_wstrb),
      .sel_mem(sel_mem), .sel_gpio(sel_gpio), .sel_uart(sel_uart), .sel_i2c(sel_i2c),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   int order [8];
   int n_ack, n_both, m0_done, m1_done;

   initial begin
      rst_n = 1'b0;
      m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_wdata = '0; m0_wstrb = '0;
      m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_wdata = '0; m1_wstrb = '0;
      bus_ready = 1'b0; bus_rdata = '0;
      step(); step();

      // Reset state.
      check("rst_bus_valid", 32'(bus_valid), 0);
      check("rst_sel", 32'({sel_i2c, sel_uart, sel_gpio, sel_mem}), 0);
      check("rst_acks", 32'({m1_ack, m0_ack}), 0);
      check("rst_bus_addr", bus_addr, 0);
      rst_n = 1'b1;

      // Simultaneous requests right after reset: strict alternation, m0 first.
      m0_req = 1'b1; m0_addr = 32'h0000_0100;
      m1_req = 1'b1; m1_addr = 32'h4000_0000;
      bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
      n_ack = 0; n_both = 0; m0_done = 0; m1_done = 0;
      for (int c = 0; c < 40 && n_ack < 6; c++) begin
         step();
         if (m0_ack && m1_ack) n_both++;
         if (m0_ack && n_ack < 8) begin
            order[n_ack] = 0; n_ack++; m0_done++;
            if (m0_done == 3) m0_req = 1'b0;
         end
         if (m1_ack && n_ack < 8) begin
            order[n_ack] = 1; n_ack++; m1_done++;
            if (m1_done == 3) m1_req = 1'b0;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0; bus_ready = 1'b0;
      check("rr_ack_count", n_ack, 6);
      check("rr_both_acked", n_both, 0);
      for (int i = 0; i < 6; i++) check($sformatf("rr_order_%0d", i), order[i], i % 2);
      step();

      // m0 read from mem, ready on the first ACCESS cycle; wstrb forced 0 on read.
      m0_req = 1'b1; m0_addr = 32'h0000_0010; m0_we = 1'b0; m0_wstrb = 4'hF;
      bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      step();
      check("rd_bus_valid", 32'(bus_valid), 1);
      check("rd_sel", 32'({sel_i2c, sel_uart, sel_gpio, sel_mem}), 32'b0001);
      check("rd_bus_addr", bus_addr, 32'h0000_0010);
      check("rd_bus_wstrb", 32'(bus_wstrb), 0);
      check("rd_early_ack", 32'(m0_ack), 0);
      step();
      check("rd_ack", 32'({m1_ack, m0_ack}), 32'b01);
      check("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
      check("rd_err", 32'(m0_err), 0);
      check("rd_valid_drop", 32'(bus_valid), 0);
      m0_req = 1'b0; bus_ready = 1'b0;
      step();
      check("rd_ack_pulse", 32'(m0_ack), 0);
      check("rd_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

      // m1 write to uart; write responses report rdata 0.
      m1_req = 1'b1; m1_addr = 32'h5000_0004; m1_we = 1'b1;
      m1_wdata = 32'h0000_0041; m1_wstrb = 4'h1; bus_ready = 1'b1;
      step();
      check("wr_sel", 32'({sel_i2c, sel_uart, sel_gpio, sel_mem}), 32'b0100);
      check("wr_bus_we", 32'(bus_we), 1);
      check("wr_bus_wdata", bus_wdata, 32'h0000_0041);
      check("wr_bus_wstrb", 32'(bus_wstrb), 32'h1);
      step();
      check("wr_ack", 32'({m1_ack, m0_ack}), 32'b10);
      check("wr_err", 32'(m1_err), 0);
      check("wr_rdata", m1_rdata, 0);
      m1_req = 1'b0; m1_we = 1'b0; bus_ready = 1'b0;
      step();

      // Unmapped address: no bus access, ack one cycle after the request.
      m0_req = 1'b1; m0_addr = 32'h2000_0000;
      step();
      check("um_bus_valid", 32'(bus_valid), 0);
      check("um_ack", 32'(m0_ack), 1);
      check("um_err", 32'(m0_err), 1);
      check("um_rdata", m0_rdata, 0);
      m0_req = 1'b0;
      step();
      check("um_err_hold", 32'(m0_err), 1);

      // gpio access, ready arrives on the 4th ACCESS cycle: beats the timeout.
      m0_req = 1'b1; m0_addr = 32'h4000_0008; bus_rdata = 32'h1234_5678;
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("lr_valid_c%0d", i), 32'({bus_valid, sel_gpio}), 32'b11);
      end
      bus_ready = 1'b1;
      step();
      check("lr_ack", 32'(m0_ack), 1);
      check("lr_err", 32'(m0_err), 0);
      check("lr_rdata", m0_rdata, 32'h1234_5678);
      m0_req = 1'b0; bus_ready = 1'b0;
      step();

      // gpio access, ready never arrives: exactly 4 strobe cycles then error.
      m0_req = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("to_valid_c%0d", i), 32'({bus_valid, m0_ack}), 32'b10);
      end
      step();
      check("to_valid_drop", 32'(bus_valid), 0);
      check("to_ack", 32'(m0_ack), 1);
      check("to_err", 32'(m0_err), 1);
      check("to_rdata", m0_rdata, 0);
      m0_req = 1'b0;
      step();

      // Reset in ACCESS cycle 2 aborts; the held request is re-arbitrated after.
      m1_req = 1'b1; m1_addr = 32'h6000_0000;
      step();
      check("ab_sel_i2c", 32'({bus_valid, sel_i2c}), 32'b11);
      step();
      check("ab_valid_c2", 32'(bus_valid), 1);
      rst_n = 1'b0;
      #1;
      check("ab_async_valid", 32'(bus_valid), 0);
      check("ab_async_sel", 32'(sel_i2c), 0);
      check("ab_rdata_clr", m1_rdata, 0);
      step();
      check("ab_no_ack", 32'({m1_ack, m0_ack}), 0);
      rst_n = 1'b1;
      bus_ready = 1'b1; bus_rdata = 32'hCAFE_0001;
      step();
      check("ab_regrant", 32'({bus_valid, sel_i2c, m1_ack}), 32'b110);
      step();
      check("ab_ack", 32'({m1_ack, m0_ack}), 32'b10);
      check("ab_rdata", m1_rdata, 32'hCAFE_0001);
      m1_req = 1'b0; bus_ready = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
